// File: rtl/noc_traffic_gen.sv
// Packet source for the ROWS x COLS mesh: all-to-all sweep, single-source broadcast
// and LFSR-random pairs, each emitted as a fully routed packet on one valid/ready port.
module noc_traffic_gen #(
  parameter int          COLS      = 5,
  parameter int          ROWS      = 3,
  parameter int          NODE_W    = 4,
  parameter int          HOP_W     = 3,
  parameter int          DATA_W    = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         PKT_W     = DATA_W + 2*HOP_W + 2 + 2*NODE_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [NODE_W-1:0] src_sel,
  input  logic [15:0]       num_pkts,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PKT_W-1:0]  pkt_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       sent_count
);

  localparam int              NODES    = ROWS * COLS;
  localparam logic [NODE_W:0] N_NODES  = (NODE_W+1)'(NODES);
  localparam logic [NODE_W:0] ONE_WIDE = (NODE_W+1)'(1);
  localparam logic [NODE_W-1:0] ONE_NODE = NODE_W'(1);
  localparam int Y_DIR_O = DATA_W + HOP_W;
  localparam int X_HOP_O = DATA_W + HOP_W + 1;
  localparam int X_DIR_O = DATA_W + 2*HOP_W + 1;
  localparam int DST_O   = DATA_W + 2*HOP_W + 2;
  localparam int SRC_O   = DST_O + NODE_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_e;
  typedef enum logic [1:0] {M_A2A, M_BCAST, M_RAND, M_RSVD} mode_e;

  // Routing fields derive from the (col,row) split of each node index.
  function automatic logic [PKT_W-1:0] build_pkt(input logic [NODE_W-1:0] s,
                                                 input logic [NODE_W-1:0] d,
                                                 input logic [15:0]       seq);
    int sc, sr, dc, dr;
    logic [PKT_W-1:0] p;
    sc = 32'(s) % COLS;
    sr = 32'(s) / COLS;
    dc = 32'(d) % COLS;
    dr = 32'(d) / COLS;
    p  = '0;
    p[DATA_W-1:0] = DATA_W'(seq);
    if (dr > sr) begin
      p[Y_DIR_O]          = 1'b1;
      p[DATA_W +: HOP_W]  = HOP_W'(dr - sr);
    end else begin
      p[DATA_W +: HOP_W]  = HOP_W'(sr - dr);
    end
    if (dc > sc) begin
      p[X_DIR_O]          = 1'b1;
      p[X_HOP_O +: HOP_W] = HOP_W'(dc - sc);
    end else begin
      p[X_HOP_O +: HOP_W] = HOP_W'(sc - dc);
    end
    p[DST_O +: NODE_W] = d;
    p[SRC_O +: NODE_W] = s;
    return p;
  endfunction

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [NODE_W-1:0]  sel_q, sel_d;
  logic [15:0]        num_q, num_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [NODE_W-1:0]  it_src_q, it_src_d;
  logic [NODE_W-1:0]  it_dst_q, it_dst_d;

  // Next pair of the sweep; one extra bit so the wrap past N is visible.
  logic [NODE_W:0] a2a_s_n, a2a_d_n, bc_d_n;
  logic            a2a_more, bc_more;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a2a_d_n = {1'b0, it_dst_q};
    a2a_s_n = {1'b0, it_src_q} + ONE_WIDE;
    if (a2a_s_n == a2a_d_n) a2a_s_n = a2a_s_n + ONE_WIDE;
    if (a2a_s_n >= N_NODES) begin
      a2a_s_n = '0;
      a2a_d_n = a2a_d_n + ONE_WIDE;
    end
    a2a_more = (a2a_d_n < N_NODES);
  end

  always_comb begin
    bc_d_n = {1'b0, it_dst_q} + ONE_WIDE;
    if (bc_d_n == {1'b0, sel_q}) bc_d_n = bc_d_n + ONE_WIDE;
    bc_more = (bc_d_n < N_NODES);
  end

  logic [NODE_W-1:0] cand_src, cand_dst;
  logic              cand_ok;
  logic [15:0]       lfsr_step;

  assign cand_src  = lfsr_q[NODE_W-1:0];
  assign cand_dst  = lfsr_q[2*NODE_W-1:NODE_W];
  assign cand_ok   = ({1'b0, cand_src} < N_NODES) && ({1'b0, cand_dst} < N_NODES) &&
                     (cand_src != cand_dst);
  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  logic try_rand;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sel_d    = sel_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    valid_d  = valid_q;
    pkt_d    = pkt_q;
    lfsr_d   = lfsr_q;
    it_src_d = it_src_q;
    it_dst_d = it_dst_q;
    try_rand = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
          mode_d  = mode_e'(mode);
          sel_d   = src_sel;
          num_d   = num_pkts;
          lfsr_d  = LFSR_SEED;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        case (mode_q)
          M_A2A: begin
            it_src_d = ONE_NODE;
            it_dst_d = '0;
            pkt_d    = build_pkt(ONE_NODE, '0, '0);
            valid_d  = 1'b1;
          end
          M_BCAST: begin
            if ({1'b0, sel_q} >= N_NODES) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              it_dst_d = (sel_q == '0) ? ONE_NODE : '0;
              pkt_d    = build_pkt(sel_q, it_dst_d, '0);
              valid_d  = 1'b1;
            end
          end
          M_RAND: begin
            if (num_q == '0) state_d = S_DONE;
            else             try_rand = 1'b1;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_SEND: begin
        if (valid_q && pkt_ready) begin
          cnt_d   = cnt_q + 16'd1;
          valid_d = 1'b0;
          case (mode_q)
            M_A2A: begin
              if (a2a_more) begin
                it_src_d = a2a_s_n[NODE_W-1:0];
                it_dst_d = a2a_d_n[NODE_W-1:0];
                pkt_d    = build_pkt(it_src_d, it_dst_d, cnt_d);
                valid_d  = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end
            M_BCAST: begin
              if (bc_more) begin
                it_dst_d = bc_d_n[NODE_W-1:0];
                pkt_d    = build_pkt(sel_q, it_dst_d, cnt_d);
                valid_d  = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end
            default: begin
              if (cnt_d != num_q) try_rand = 1'b1;
              else                state_d  = S_DONE;
            end
          endcase
        end else if (!valid_q) begin
          try_rand = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A rejected random candidate still consumes one LFSR step and one cycle.
    if (try_rand) begin
      lfsr_d  = lfsr_step;
      valid_d = cand_ok;
      if (cand_ok) pkt_d = build_pkt(cand_src, cand_dst, cnt_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= M_A2A;
      sel_q    <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      pkt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      it_src_q <= '0;
      it_dst_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      pkt_q    <= pkt_d;
      lfsr_q   <= lfsr_d;
      it_src_q <= it_src_d;
      it_dst_q <= it_dst_d;
    end
  end

  assign pkt_valid  = valid_q;
  assign pkt_data   = pkt_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign sent_count = cnt_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen at default parameters (5x3 mesh, 57-bit packets).
module tb_noc_traffic_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  src_sel;
  logic [15:0] num_pkts;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [56:0] pkt_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] sent_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  noc_traffic_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_sel    (src_sel),
    .num_pkts   (num_pkts),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sent_count (sent_count)
  );

  // Handshake log and done-pulse counter, sampled mid-cycle.
  logic [56:0] got_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && pkt_valid && pkt_ready) got_q.push_back(pkt_data);
    if (!rst && done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Config is scrambled right after the start edge; the run must use the captured copy.
  task automatic do_start(input logic [1:0] m, input logic [3:0] sel, input logic [15:0] n);
    mode     = m;
    src_sel  = sel;
    num_pkts = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    mode     = ~m;
    src_sel  = ~sel;
    num_pkts = ~n;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [56:0] mk(input int s, input int d, input int seq);
    int sc, sr, dc, dr;
    logic xd, yd;
    logic [2:0] xh, yh;
    sc = s % 5; sr = s / 5;
    dc = d % 5; dr = d / 5;
    xd = (dc > sc);
    yd = (dr > sr);
    xh = 3'(xd ? dc - sc : sc - dc);
    yh = 3'(yd ? dr - sr : sr - dr);
    return {1'b0, 4'(s), 4'(d), xd, xh, yd, yh, 40'(seq)};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  initial begin
    int          base, dbase, bad, k, got;
    bit          seen;
    logic [56:0] held, p;
    logic [56:0] exp_q[$];
    logic [56:0] run1[$];
    logic [15:0] lf;
    int          ps, pd;

    rst = 1'b1; start = 1'b0; mode = '0; src_sel = '0; num_pkts = '0; pkt_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", pkt_valid, 0);
    check("rst_data", pkt_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", sent_count, 0);
    rst = 1'b0;
    tick();

    // All-to-all sweep, ready always high
    base = got_q.size(); dbase = done_cnt;
    do_start(2'd0, 4'd0, 16'd0);
    check("a2a_load_valid", pkt_valid, 0);
    check("a2a_load_busy", busy, 1);
    tick();
    check("a2a_first_valid", pkt_valid, 1);
    check("a2a_first_pkt", pkt_data, 57'h0010_1000_0000_0000);
    wait_done(400, seen);
    check("a2a_done_seen", seen, 1);
    tick();
    check("a2a_handshakes", got_q.size() - base, 210);
    check("a2a_done_pulses", done_cnt - dbase, 1);
    check("a2a_sent_count", sent_count, 210);
    check("a2a_busy_after", busy, 0);
    check("a2a_err", err, 0);
    bad = 0; k = 0;
    for (int d = 0; d < 15; d++)
      for (int s = 0; s < 15; s++)
        if (s != d) begin
          if (base + k >= got_q.size() || got_q[base + k] !== mk(s, d, k)) bad++;
          k++;
        end
    check("a2a_sequence_bad", bad, 0);

    // Broadcast from node 7
    base = got_q.size(); dbase = done_cnt;
    do_start(2'd1, 4'd7, 16'd0);
    wait_done(100, seen);
    check("bc7_done_seen", seen, 1);
    tick();
    check("bc7_handshakes", got_q.size() - base, 14);
    check("bc7_done_pulses", done_cnt - dbase, 1);
    bad = 0; k = 0;
    for (int d = 0; d < 15; d++)
      if (d != 7) begin
        if (base + k >= got_q.size() || got_q[base + k] !== mk(7, d, k)) bad++;
        else if (got_q[base + k][51:48] == 4'd7) bad++;
        k++;
      end
    check("bc7_sequence_bad", bad, 0);
    p = (got_q.size() >= base + 14) ? got_q[base + 13] : '0;
    check("bc7_pkt_dst14", p, 57'h7E_A900_0000_000D);

    // Broadcast from node 0 with a 5-cycle stall after four packets
    base = got_q.size(); dbase = done_cnt;
    do_start(2'd1, 4'd0, 16'd0);
    for (int i = 0; i < 50; i++) begin
      if (sent_count == 16'd4) break;
      tick();
    end
    check("bp_reached_4", sent_count, 4);
    pkt_ready = 1'b0;
    @(negedge clk);
    held = pkt_data;
    check("bp_held_pkt", held, mk(0, 5, 4));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!pkt_valid || pkt_data !== held) bad++;
    end
    check("bp_stall_unstable", bad, 0);
    @(posedge clk); #1;
    check("bp_count_frozen", sent_count, 4);
    pkt_ready = 1'b1;
    wait_done(100, seen);
    check("bp_done_seen", seen, 1);
    tick();
    check("bp_handshakes", got_q.size() - base, 14);
    bad = 0;
    for (int d = 1; d < 15; d++)
      if (base + d - 1 >= got_q.size() || got_q[base + d - 1] !== mk(0, d, d - 1)) bad++;
    check("bp_sequence_bad", bad, 0);

    // Random pairs, 20 packets, run twice
    lf = 16'hACE1; got = 0;
    while (got < 20) begin
      ps = int'(lf[3:0]); pd = int'(lf[7:4]);
      if (ps < 15 && pd < 15 && ps != pd) begin
        exp_q.push_back(mk(ps, pd, got));
        got++;
      end
      lf = lfsr_next(lf);
    end
    base = got_q.size();
    do_start(2'd2, 4'd0, 16'd20);
    wait_done(1000, seen);
    check("rnd1_done_seen", seen, 1);
    tick();
    check("rnd1_handshakes", got_q.size() - base, 20);
    check("rnd1_sent_count", sent_count, 20);
    check("rnd1_err", err, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (base + i >= got_q.size()) begin
        bad++;
      end else begin
        p  = got_q[base + i];
        ps = int'(p[55:52]); pd = int'(p[51:48]);
        if (ps >= 15 || pd >= 15 || ps == pd || p !== mk(ps, pd, i)) bad++;
        run1.push_back(p);
      end
    end
    check("rnd1_field_bad", bad, 0);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (i >= run1.size() || run1[i] !== exp_q[i]) bad++;
    check("rnd1_model_bad", bad, 0);
    base = got_q.size();
    do_start(2'd2, 4'd0, 16'd20);
    wait_done(1000, seen);
    check("rnd2_done_seen", seen, 1);
    tick();
    check("rnd2_handshakes", got_q.size() - base, 20);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (base + i >= got_q.size() || i >= run1.size() || got_q[base + i] !== run1[i]) bad++;
    check("rnd2_repeat_bad", bad, 0);

    // Bad configurations
    base = got_q.size(); dbase = done_cnt;
    do_start(2'd1, 4'd15, 16'd0);
    wait_done(20, seen);
    check("badsel_done_seen", seen, 1);
    tick();
    check("badsel_err", err, 1);
    check("badsel_handshakes", got_q.size() - base, 0);
    check("badsel_done_pulses", done_cnt - dbase, 1);
    repeat (3) tick();
    check("badsel_err_sticky", err, 1);

    base = got_q.size(); dbase = done_cnt;
    do_start(2'd3, 4'd0, 16'd0);
    check("m3_err_cleared", err, 0);
    wait_done(20, seen);
    check("m3_done_seen", seen, 1);
    tick();
    check("m3_err", err, 1);
    check("m3_handshakes", got_q.size() - base, 0);
    check("m3_done_pulses", done_cnt - dbase, 1);

    base = got_q.size(); dbase = done_cnt;
    do_start(2'd2, 4'd0, 16'd0);
    wait_done(20, seen);
    check("n0_done_seen", seen, 1);
    tick();
    check("n0_err", err, 0);
    check("n0_handshakes", got_q.size() - base, 0);
    check("n0_done_pulses", done_cnt - dbase, 1);

    // Reset in the middle of an all-to-all run
    dbase = done_cnt;
    do_start(2'd0, 4'd0, 16'd0);
    for (int i = 0; i < 100; i++) begin
      if (sent_count == 16'd30) break;
      tick();
    end
    check("mrst_reached_30", sent_count, 30);
    rst = 1'b1;
    tick();
    check("mrst_valid", pkt_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_count", sent_count, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("mrst_no_done", done_cnt - dbase, 0);
    check("mrst_idle_busy", busy, 0);
    base = got_q.size();
    do_start(2'd0, 4'd0, 16'd0);
    tick();
    check("mrst_restart_pkt", pkt_data, 57'h0010_1000_0000_0000);
    check("mrst_restart_count", sent_count, 0);
    wait_done(400, seen);
    check("mrst_done_seen", seen, 1);
    tick();
    check("mrst_handshakes", got_q.size() - base, 210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
